nanci_sort_sched: RTL and testbench

NANCI_SORT_SCHED -- requirements
Module: nanci_sort_sched

---
 rtl/nanci_sort_sched.sv | 127 ++++++++++++
 tb/tb_nanci_sort_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nanci_sort_sched.sv
// Phase scheduler for an N x N shear-sort mesh: sequences row/column compare-exchange phases.
// Optional pause input enabled by defining NANCI_SORT_SCHED_PAUSE_EN.
module nanci_sort_sched #(
   parameter int N           = 4,
   parameter int SORT_CYCLES = 1,
   parameter int NUM_ROUNDS  = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_start,
   input  logic                              i_abort,
`ifdef NANCI_SORT_SCHED_PAUSE_EN
   input  logic                              i_pause,
`endif
   output logic [1:0]                        o_dir,
   output logic                              o_step_en,
   output logic                              o_busy,
   output logic                              o_done,
   output logic [$clog2(NUM_ROUNDS+1)-1:0]   o_round,
   output logic [1:0]                        o_state
);

   localparam int RW = $clog2(NUM_ROUNDS + 1);
   localparam int SW = $clog2(N);
   localparam int CW = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ROW  = 2'd1;
   localparam logic [1:0] S_COL  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS);
   localparam logic [SW-1:0] LAST_STEP  = SW'(N - 1);
   localparam logic [CW-1:0] LAST_CYC   = CW'(SORT_CYCLES - 1);

   logic [1:0]    state, n_state;
   logic [SW-1:0] step, n_step;
   logic [CW-1:0] cyc, n_cyc;
   logic [RW-1:0] n_round;
   logic          active;
   logic          freeze;
   logic          n_busy;

   assign active = (state == S_ROW) || (state == S_COL);

`ifdef NANCI_SORT_SCHED_PAUSE_EN
   assign freeze = active && i_pause && !i_abort;
`else
   assign freeze = 1'b0;
`endif

   always_comb begin
      n_state = state;
      n_step  = step;
      n_cyc   = cyc;
      n_round = o_round;
      case (state)
         S_IDLE: begin
            n_step  = '0;
            n_cyc   = '0;
            n_round = '0;
            if (i_start && !i_abort) n_state = S_ROW;
         end
         S_ROW, S_COL: begin
            if (i_abort) begin
               n_state = S_IDLE;
               n_step  = '0;
               n_cyc   = '0;
               n_round = '0;
            end else if (freeze) begin
               n_state = state;
            end else if (cyc == LAST_CYC) begin
               n_cyc = '0;
               if (step == LAST_STEP) begin
                  // Phase boundary: counters restart, round advances after each column phase.
                  n_step = '0;
                  if (state == S_COL) begin
                     n_state = S_ROW;
                     n_round = o_round + RW'(1);
                  end else if (o_round == LAST_ROUND) begin
                     n_state = S_DONE;
                  end else begin
                     n_state = S_COL;
                  end
               end else begin
                  n_step = step + SW'(1);
               end
            end else begin
               n_cyc = cyc + CW'(1);
            end
         end
         default: begin
            n_state = S_IDLE;
            n_step  = '0;
            n_cyc   = '0;
         end
      endcase
   end

   assign n_busy = (n_state == S_ROW) || (n_state == S_COL);

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         step      <= '0;
         cyc       <= '0;
         o_round   <= '0;
         o_dir     <= 2'b00;
         o_step_en <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
      end else begin
         state     <= n_state;
         step      <= n_step;
         cyc       <= n_cyc;
         o_round   <= (n_state == S_IDLE) ? '0 : n_round;
         o_dir     <= n_busy ? {(n_state == S_COL), n_step[0]} : 2'b00;
         o_step_en <= n_busy && (n_cyc == LAST_CYC) && !freeze;
         o_busy    <= n_busy;
         o_done    <= (n_state == S_DONE);
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_nanci_sort_sched.sv
// Directed bench for nanci_sort_sched: N=2, NUM_ROUNDS=1, with SORT_CYCLES=1 and SORT_CYCLES=3 instances.
module tb_nanci_sort_sched;

   logic clk;
   logic rst;
   logic i_start;
   logic i_abort;
`ifdef NANCI_SORT_SCHED_PAUSE_EN
   logic i_pause;
`endif

   logic [1:0] dir1, dir3;
   logic       en1, en3, busy1, busy3, done1, done3;
   logic [0:0] round1, round3;
   logic [1:0] state1, state3;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_dir [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   nanci_sort_sched #(.N(2), .SORT_CYCLES(1), .NUM_ROUNDS(1)) dut1 (
      .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
`ifdef NANCI_SORT_SCHED_PAUSE_EN
      .i_pause(i_pause),
`endif
      .o_dir(dir1), .o_step_en(en1), .o_busy(busy1), .o_done(done1),
      .o_round(round1), .o_state(state1)
   );

   nanci_sort_sched #(.N(2), .SORT_CYCLES(3), .NUM_ROUNDS(1)) dut3 (
      .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
`ifdef NANCI_SORT_SCHED_PAUSE_EN
      .i_pause(i_pause),
`endif
      .o_dir(dir3), .o_step_en(en3), .o_busy(busy3), .o_done(done3),
      .o_round(round3), .o_state(state3)
   );

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      i_start = 1'b0;
      i_abort = 1'b0;
`ifdef NANCI_SORT_SCHED_PAUSE_EN
      i_pause = 1'b0;
`endif
      rst = 1'b0;
      tick();
      tick();
      #2 rst = 1'b1;
      tick();
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({dir1, en1, busy1, done1, round1, state1} !== 7'b0) begin
         errors++;
         $display("FAIL reset_state: got dir=%0d en=%0d busy=%0d done=%0d round=%0d state=%0d, need all 0",
                  dir1, en1, busy1, done1, round1, state1);
      end
   endtask

   task automatic test_basic_run();
      logic [0:0] exp_round;
      apply_reset();
      pulse_start();
      for (int k = 0; k < 6; k++) begin
         exp_round = (k >= 4) ? 1'b1 : 1'b0;
         checks++;
         if (dir1 !== exp_dir[k] || en1 !== 1'b1 || busy1 !== 1'b1 || done1 !== 1'b0 || round1 !== exp_round) begin
            errors++;
            $display("FAIL basic_cycle%0d: got dir=%0d en=%0d busy=%0d done=%0d round=%0d, need dir=%0d en=1 busy=1 done=0 round=%0d",
                     k, dir1, en1, busy1, done1, round1, exp_dir[k], exp_round);
         end
         tick();
      end
      checks++;
      if (done1 !== 1'b1 || busy1 !== 1'b0 || en1 !== 1'b0 || dir1 !== 2'b00) begin
         errors++;
         $display("FAIL basic_done: got done=%0d busy=%0d en=%0d dir=%0d, need done=1 busy=0 en=0 dir=0",
                  done1, busy1, en1, dir1);
      end
      tick();
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0 || round1 !== 1'b0 || state1 !== 2'd0) begin
         errors++;
         $display("FAIL basic_idle: got done=%0d busy=%0d round=%0d state=%0d, need 0 0 0 0",
                  done1, busy1, round1, state1);
      end
   endtask

   task automatic test_sort_cycles();
      logic exp_en;
      apply_reset();
      pulse_start();
      for (int k = 0; k < 18; k++) begin
         exp_en = ((k % 3) == 2);
         checks++;
         if (dir3 !== exp_dir[k/3] || en3 !== exp_en || busy3 !== 1'b1 || done3 !== 1'b0) begin
            errors++;
            $display("FAIL slow_cycle%0d: got dir=%0d en=%0d busy=%0d done=%0d, need dir=%0d en=%0d busy=1 done=0",
                     k, dir3, en3, busy3, done3, exp_dir[k/3], exp_en);
         end
         tick();
      end
      checks++;
      if (done3 !== 1'b1 || busy3 !== 1'b0) begin
         errors++;
         $display("FAIL slow_done: got done=%0d busy=%0d, need done=1 busy=0", done3, busy3);
      end
   endtask

   task automatic test_abort();
      int done_seen;
      apply_reset();
      pulse_start();
      tick();
      tick();
      checks++;
      if (dir1 !== 2'd2 || busy1 !== 1'b1) begin
         errors++;
         $display("FAIL abort_pre: got dir=%0d busy=%0d, need dir=2 busy=1", dir1, busy1);
      end
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
      checks++;
      if (busy1 !== 1'b0 || en1 !== 1'b0 || dir1 !== 2'b00 || round1 !== 1'b0 || done1 !== 1'b0 || state1 !== 2'd0) begin
         errors++;
         $display("FAIL abort_idle: got busy=%0d en=%0d dir=%0d round=%0d done=%0d state=%0d, need all 0",
                  busy1, en1, dir1, round1, done1, state1);
      end
      done_seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (done1 === 1'b1 || busy1 === 1'b1) done_seen++;
         tick();
      end
      checks++;
      if (done_seen !== 0) begin
         errors++;
         $display("FAIL abort_quiet: got %0d active/done cycles after abort, need 0", done_seen);
      end
   endtask

   task automatic test_start_held();
      int busy_cnt;
      apply_reset();
      i_start = 1'b1;
      tick();
      busy_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         if (busy1 === 1'b1) busy_cnt++;
         tick();
      end
      checks++;
      if (busy_cnt !== 6 || done1 !== 1'b1) begin
         errors++;
         $display("FAIL held_run: got busy_cycles=%0d done=%0d, need 6 and 1", busy_cnt, done1);
      end
      tick();
      checks++;
      if (busy1 !== 1'b0 || state1 !== 2'd0) begin
         errors++;
         $display("FAIL held_gap: got busy=%0d state=%0d, need busy=0 state=0", busy1, state1);
      end
      tick();
      checks++;
      if (busy1 !== 1'b1 || dir1 !== 2'd0 || en1 !== 1'b1) begin
         errors++;
         $display("FAIL held_restart: got busy=%0d dir=%0d en=%0d, need busy=1 dir=0 en=1", busy1, dir1, en1);
      end
      i_start = 1'b0;
      i_abort = 1'b1;
      tick();
      i_abort = 1'b0;
   endtask

   task automatic test_start_abort_together();
      apply_reset();
      i_start = 1'b1;
      i_abort = 1'b1;
      tick();
      tick();
      i_start = 1'b0;
      i_abort = 1'b0;
      checks++;
      if (busy1 !== 1'b0 || state1 !== 2'd0 || en1 !== 1'b0) begin
         errors++;
         $display("FAIL start_abort: got busy=%0d state=%0d en=%0d, need 0 0 0", busy1, state1, en1);
      end
   endtask

   task automatic test_reset_mid_run();
      int busy_cnt;
      int done_cnt;
      apply_reset();
      pulse_start();
      tick();
      tick();
      checks++;
      if (state1 !== 2'd2) begin
         errors++;
         $display("FAIL midrst_col: got state=%0d, need 2", state1);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({dir1, en1, busy1, done1, round1, state1} !== 7'b0) begin
         errors++;
         $display("FAIL midrst_async: got dir=%0d en=%0d busy=%0d done=%0d round=%0d state=%0d, need all 0",
                  dir1, en1, busy1, done1, round1, state1);
      end
      tick();
      #2 rst = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (done1 === 1'b1 || busy1 === 1'b1) done_cnt++;
      end
      checks++;
      if (done_cnt !== 0) begin
         errors++;
         $display("FAIL midrst_quiet: got %0d active/done cycles, need 0", done_cnt);
      end
      pulse_start();
      busy_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k < 12; k++) begin
         if (busy1 === 1'b1) busy_cnt++;
         if (done1 === 1'b1) done_cnt++;
         tick();
      end
      checks++;
      if (busy_cnt !== 6 || done_cnt !== 1) begin
         errors++;
         $display("FAIL midrst_rerun: got busy_cycles=%0d done_pulses=%0d, need 6 and 1", busy_cnt, done_cnt);
      end
   endtask

`ifdef NANCI_SORT_SCHED_PAUSE_EN
   task automatic test_pause();
      int busy_cnt;
      int done_cnt;
      apply_reset();
      pulse_start();
      busy_cnt = 1;
      tick();
      busy_cnt++;
      i_pause = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (busy1 === 1'b1) busy_cnt++;
         checks++;
         if (dir1 !== 2'd1 || en1 !== 1'b0 || busy1 !== 1'b1) begin
            errors++;
            $display("FAIL pause_hold%0d: got dir=%0d en=%0d busy=%0d, need dir=1 en=0 busy=1",
                     k, dir1, en1, busy1);
         end
      end
      i_pause = 1'b0;
      done_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (busy1 === 1'b1) busy_cnt++;
         if (done1 === 1'b1) done_cnt++;
      end
      checks++;
      if (busy_cnt !== 10 || done_cnt !== 1) begin
         errors++;
         $display("FAIL pause_run: got busy_cycles=%0d done_pulses=%0d, need 10 and 1", busy_cnt, done_cnt);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_run();
      test_sort_cycles();
      test_abort();
      test_start_held();
      test_start_abort_together();
      test_reset_mid_run();
`ifdef NANCI_SORT_SCHED_PAUSE_EN
      test_pause();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
